// File: rtl/cochlea_ctrl_pkg.sv
// Shared defaults for the cochlea channel controller and its output FIFO.
package cochlea_ctrl_pkg;

  localparam int DIV_W_DEF      = 8;
  localparam int WORD_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  // One extra pointer bit distinguishes full from empty.
  function automatic int fifoPtrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FIFO_PTR_W = fifoPtrWidth(FIFO_DEPTH_DEF);

endpackage

// File: rtl/cochlea_word_fifo.sv
// Synchronous word FIFO with a registered head word; reports pushes dropped
// while full so the owner can keep a sticky overflow flag.
module cochlea_word_fifo
  import cochlea_ctrl_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int PTR_W = fifoPtrWidth(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_headNext;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] w_wrNext;
  logic [PTR_W-1:0] w_rdNext;
  logic [PTR_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_pushOk;

  assign w_count  = r_wrPtr - r_rdPtr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == PTR_W'(DEPTH));
  assign w_pop    = i_pop && !w_empty;
  assign w_pushOk = i_push && (!w_full || w_pop);
  assign w_wrNext = r_wrPtr + PTR_W'(w_pushOk);
  assign w_rdNext = r_rdPtr + PTR_W'(w_pop);

  // The head follows the entry that will be at the read pointer next cycle,
  // bypassing the array when that entry is being written right now.
  always_comb begin
    w_headNext = r_head;
    if (w_wrNext != w_rdNext) begin
      if (w_pushOk && (r_wrPtr[IDX_W-1:0] == w_rdNext[IDX_W-1:0]))
        w_headNext = i_data;
      else
        w_headNext = r_mem[w_rdNext[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_pushOk)
      r_mem[r_wrPtr[IDX_W-1:0]] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_head  <= '0;
    end else begin
      r_wrPtr <= w_wrNext;
      r_rdPtr <= w_rdNext;
      r_head  <= w_headNext;
    end
  end

  assign o_data  = r_head;
  assign o_valid = !w_empty;
  assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/cochlea_chan_ctrl.sv
// Digital controller for one analog cochlea channel: switched-cap clocks, LO,
// comparator capture, feedback bit and word packing. Option: CHAN_LO_DEMOD_EN.
module cochlea_chan_ctrl
  import cochlea_ctrl_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en,
  input  logic [DIV_W-1:0]  cclk_div,
  input  logic [DIV_W-1:0]  lo_div,
  output logic              cclk,
  output logic              div2,
  output logic              lo,
  output logic              fb1,
  input  logic              high_buf,
  input  logic              phi1b_dig,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [DIV_W-1:0]  r_cclkCnt;
  logic [DIV_W-1:0]  r_loCnt;
  logic              r_cclk;
  logic              r_div2;
  logic              r_lo;
  logic [1:0]        r_phiSync;
  logic [1:0]        r_highSync;
  logic              r_phiPrev;
  logic              r_fb1;
  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bitCnt;
  logic              r_ovf;
  logic              w_capture;
  logic              w_bit;
  logic              w_wordDone;
  logic              w_drop;

  // div2 and the LO counter both advance on the cycle cclk goes 0->1.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cclkCnt <= '0;
      r_cclk    <= 1'b0;
      r_div2    <= 1'b0;
      r_loCnt   <= '0;
      r_lo      <= 1'b0;
    end else if (!en) begin
      r_cclkCnt <= '0;
      r_cclk    <= 1'b0;
      r_div2    <= 1'b0;
      r_loCnt   <= '0;
      r_lo      <= 1'b0;
    end else if (r_cclkCnt == '0) begin
      r_cclkCnt <= cclk_div;
      r_cclk    <= ~r_cclk;
      if (!r_cclk) begin
        r_div2 <= ~r_div2;
        if (r_loCnt == lo_div) begin
          r_loCnt <= '0;
          r_lo    <= ~r_lo;
        end else begin
          r_loCnt <= r_loCnt + DIV_W'(1);
        end
      end
    end else begin
      r_cclkCnt <= r_cclkCnt - DIV_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_phiSync  <= '0;
      r_highSync <= '0;
      r_phiPrev  <= 1'b0;
    end else begin
      r_phiSync  <= {r_phiSync[0], phi1b_dig};
      r_highSync <= {r_highSync[0], high_buf};
      r_phiPrev  <= r_phiSync[1];
    end
  end

  assign w_capture = en && r_phiSync[1] && !r_phiPrev;

`ifdef CHAN_LO_DEMOD_EN
  assign w_bit = r_highSync[1] ^ r_lo;
`else
  assign w_bit = r_highSync[1];
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      r_fb1 <= 1'b0;
    else if (w_capture)
      r_fb1 <= r_highSync[1];
  end

  // A full word sits one cycle in the packer and is pushed on the next edge,
  // even if en has just dropped, since it is no longer a partial word.
  assign w_wordDone = (r_bitCnt == CNT_W'(WORD_W));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else if (!en) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else if (w_capture) begin
      r_shift  <= {r_shift[WORD_W-2:0], w_bit};
      r_bitCnt <= w_wordDone ? CNT_W'(1) : r_bitCnt + CNT_W'(1);
    end else if (w_wordDone) begin
      r_bitCnt <= '0;
    end
  end

  cochlea_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_push  (w_wordDone),
    .i_data  (r_shift),
    .i_pop   (word_ready),
    .o_data  (word_data),
    .o_valid (word_valid),
    .o_drop  (w_drop)
  );

  // A new drop wins over a coincident clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (clr_ovf)
      r_ovf <= 1'b0;
  end

  assign cclk     = r_cclk;
  assign div2     = r_div2;
  assign lo       = r_lo;
  assign fb1      = r_fb1;
  assign overflow = r_ovf;

endmodule

// File: doc/cochlea_chan_ctrl.md
# cochlea_chan_ctrl

Digital-side controller for one analog cochlea channel (I or Q). It generates the switched-cap clocks (cclk, div2) and the LO chopping signal that are level-shifted into the analog core. It also samples the comparator decision on each phi1 event, drives the filter feedback bit, and packs decisions into words that a downstream reader drains through a valid/ready FIFO. One instance sits per analog core, between that core and the Wishbone-side register/readout logic.

## Interface
Parameters:
- DIV_W, 8, width of clock/LO divider settings
- WORD_W, 16, bits per packed output word
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- wb_clk_i  in  1  system clock; the only clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- en  in  1  channel enable
- cclk_div  in  DIV_W  cclk half-period minus one, in wb_clk_i cycles
- lo_div  in  DIV_W  LO half-period minus one, in cclk rising edges
- cclk  out  1  switched-cap clock to level shifter
- div2  out  1  cclk divided by 2
- lo  out  1  LO mux control
- fb1  out  1  feedback bit to the level-shifter-inverter
- high_buf  in  1  comparator output, asynchronous to wb_clk_i
- phi1b_dig  in  1  phi1 event clock from the core, asynchronous
- word_data  out  WORD_W  FIFO head word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  reader accepts head word
- overflow  out  1  sticky: a completed word was dropped
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Reset values: cclk=0, div2=0, lo=0, fb1=0, word_valid=0, word_data=0, overflow=0. Divider counters, LO counter, packer and FIFO pointers are all cleared.
- cclk divider: a down-counter loads cclk_div. At 0 it toggles cclk and reloads. cclk_div=0 gives cclk = wb_clk_i/2. A new cclk_div takes effect at the next reload.
- div2 toggles on every cclk 0→1 transition.
- LO: a counter of cclk rising edges toggles lo after lo_div+1 edges and then restarts.
- en=0: cclk, div2 and lo are forced to 0 and their counters are reset on the next edge. The packer's partial word is discarded and its bit count cleared. FIFO contents and fb1 are retained.
- Capture path: phi1b_dig and high_buf each pass through a 2-flop synchronizer. A rising edge of synchronized phi1b_dig while en=1 is a capture event, and the synchronized high_buf becomes bit b.
- On a capture event, fb1 <= b.
- On a capture event, b is shifted into the packer MSB-first; the first captured bit ends up at word_data[WORD_W-1].
- When the packer holds WORD_W bits, the word is pushed to the FIFO and the bit count restarts at 0 in the same cycle.
- FIFO handshake: a pop occurs when word_valid && word_ready. word_data is stable while word_valid=1 and there is no pop.
- Full boundary: a push when full and with no simultaneous pop drops the word and sets overflow. A push and a pop in the same cycle while full are both accepted.
- Empty boundary: word_ready while empty has no effect.
- clr_ovf clears overflow. If clr_ovf coincides with a new drop, overflow stays 1.

## Timing
- phi1b_dig rising at the pin to fb1/packer update: 3 wb_clk_i edges (2 sync + edge-detect register). phi1b_dig high pulses shorter than 2 wb_clk_i periods may be missed; this is a system constraint, not a detected error.
- Word completion to word_valid=1 (FIFO empty before the push): 1 cycle.
- Pop to next word on word_data: 1 cycle. FIFO throughput is 1 word/cycle.
- en falling to cclk=0: 1 cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Reset release is synchronous to wb_clk_i.

## Configuration
- CHAN_LO_DEMOD_EN defined: the packed bit is b XOR lo, using lo as sampled at the capture event (digital chopper demodulation). fb1 still takes the raw b.
- CHAN_LO_DEMOD_EN undefined: the packed bit is b.

## Structure
- Package cochlea_ctrl_pkg holds the DIV_W/WORD_W/FIFO_DEPTH defaults and the local parameter for the FIFO pointer width, $clog2(FIFO_DEPTH)+1.
- Sub-module cochlea_word_fifo: synchronous FIFO with push/pop, full/empty and a registered head. The synchronizers, dividers and packer stay inline.

## Test plan
- Reset, cclk_div=3, en=1 -> cclk period is 8 wb_clk_i cycles, div2 period is 16, and with lo_div=1 the lo period is 32.
- Apply 16 phi1b_dig pulses with high_buf pattern 0xA5C3, MSB first -> word_data=0xA5C3 and word_valid rises 1 cycle after the 16th capture. fb1 tracks each bit 3 cycles after each phi1b_dig edge.
- word_ready=0 while 5 words complete (FIFO_DEPTH=4) -> first 4 words retained in order, overflow=1; clr_ovf then clears it.
- FIFO full with a push and pop in the same cycle -> no overflow, and order is preserved.
- Drop en after 7 captured bits, re-enable, capture 16 bits -> only the new 16 bits appear in the word.
- With CHAN_LO_DEMOD_EN, constant high_buf=1 and lo toggling -> packed bits equal ~lo at each capture event.
